// File: rtl/ps2_pkg.sv
// Shared scan-code constants, state encoding and byte classifiers
// for the PS/2 Set 2 key tracker.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_SKIP
   } ps2_state_t;

   localparam logic [7:0] B_E0 = 8'hE0;
   localparam logic [7:0] B_F0 = 8'hF0;
   localparam logic [7:0] B_E1 = 8'hE1;

   localparam logic [7:0] B_FAKE_LSH = 8'h12;
   localparam logic [7:0] B_FAKE_RSH = 8'h59;

   // {ext,code} indices the arrow/Z decoder watches
   localparam logic [8:0] K_UP    = 9'h175;
   localparam logic [8:0] K_DOWN  = 9'h172;
   localparam logic [8:0] K_LEFT  = 9'h16B;
   localparam logic [8:0] K_RIGHT = 9'h174;
   localparam logic [8:0] K_Z     = 9'h01A;

   function automatic logic is_status(input logic [7:0] b);
      return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
             (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
   endfunction

   function automatic logic is_fake(input logic [7:0] b);
      return (b == B_FAKE_LSH) || (b == B_FAKE_RSH);
   endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Idle counter for pending prefix states; clears on any byte and
// pulses o_expire on the last idle cycle so the FSM can drop the prefix.
module ps2_prefix_timer #(
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_active,
   input  logic i_byte,
   output logic o_expire
);

   localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] r_cnt;

   assign o_expire = i_active && !i_byte && (r_cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || !i_active || i_byte || o_expire) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ps2_key_tracker.sv
// Turns the Set 2 scan-code byte stream into a held-key map plus a
// one-cycle change strobe carrying the {ext,code} of the event.
module ps2_key_tracker
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES   = 2_000_000,
   parameter int PAUSE_SKIP_BYTES = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         byte_valid,
   input  logic [7:0]   byte_data,
   output logic [511:0] key_down,
   output logic [8:0]   last_change,
   output logic         been_ready
);

   localparam int SW = $clog2(PAUSE_SKIP_BYTES + 1);
   localparam logic [SW-1:0] SKIP_LOAD = SW'(PAUSE_SKIP_BYTES);

   ps2_state_t     r_state;
   ps2_state_t     w_next;
   logic [SW-1:0]  r_skip;
   logic [SW-1:0]  w_skip_nxt;
   logic [511:0]   r_key_down;
   logic [8:0]     r_last;
   logic           r_ready;
   logic           w_event;
   logic           w_make;
   logic [8:0]     w_idx;
   logic           w_expire;

   assign key_down    = r_key_down;
   assign last_change = r_last;
   assign been_ready  = r_ready;

   ps2_prefix_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_active (r_state != ST_IDLE),
      .i_byte   (byte_valid),
      .o_expire (w_expire)
   );

   always_comb begin
      w_next     = r_state;
      w_skip_nxt = r_skip;
      w_event    = 1'b0;
      w_make     = 1'b0;
      w_idx      = {1'b0, byte_data};
      if (w_expire) begin
         w_next = ST_IDLE;
      end else if (byte_valid) begin
         unique case (r_state)
            ST_IDLE: begin
               if (byte_data == B_E0) begin
                  w_next = ST_EXT;
               end else if (byte_data == B_F0) begin
                  w_next = ST_BRK;
               end else if (byte_data == B_E1) begin
                  w_next     = ST_SKIP;
                  w_skip_nxt = SKIP_LOAD;
               end else if (!is_status(byte_data)) begin
                  w_event = 1'b1;
                  w_make  = 1'b1;
               end
            end
            ST_EXT: begin
               if (byte_data == B_F0) begin
                  w_next = ST_EXT_BRK;
               end else if (byte_data == B_E1) begin
                  w_next     = ST_SKIP;
                  w_skip_nxt = SKIP_LOAD;
               end else if (is_fake(byte_data)) begin
                  w_next = ST_IDLE;
               end else if (byte_data != B_E0) begin
                  w_event = 1'b1;
                  w_make  = 1'b1;
                  w_idx   = {1'b1, byte_data};
               end
            end
            ST_BRK: begin
               // E0 after F0 is a reordered extended break
               if (byte_data == B_E0) begin
                  w_next = ST_EXT_BRK;
               end else if (byte_data != B_F0) begin
                  w_event = 1'b1;
               end
            end
            ST_EXT_BRK: begin
               if (is_fake(byte_data)) begin
                  w_next = ST_IDLE;
               end else if (byte_data != B_E0 && byte_data != B_F0) begin
                  w_event = 1'b1;
                  w_idx   = {1'b1, byte_data};
               end
            end
            ST_SKIP: begin
               w_skip_nxt = r_skip - 1'b1;
               if (r_skip == SW'(1)) begin
                  w_next = ST_IDLE;
               end
            end
            default: w_next = ST_IDLE;
         endcase
         if (w_event) begin
            w_next = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_skip     <= '0;
         r_key_down <= '0;
         r_last     <= '0;
         r_ready    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_skip  <= w_skip_nxt;
         r_ready <= w_event;
         if (w_event) begin
            r_key_down[w_idx] <= w_make;
            r_last            <= w_idx;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed scan-code scenarios and random
// byte streams against a prefix-flag reference model.
module tb_ps2_key_tracker;

   localparam int T    = 16;
   localparam int SKIP = 7;

   logic         clk = 1'b0;
   logic         rst;
   logic         byte_valid;
   logic [7:0]   byte_data;
   logic [511:0] key_down;
   logic [8:0]   last_change;
   logic         been_ready;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;

   bit           m_ext;
   bit           m_brk;
   int           m_skip;
   int           m_gap;
   logic [511:0] m_kd;
   logic [8:0]   m_lc;
   logic         m_br;

   always #5 clk = ~clk;

   ps2_key_tracker #(
      .TIMEOUT_CYCLES   (T),
      .PAUSE_SKIP_BYTES (SKIP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .key_down    (key_down),
      .last_change (last_change),
      .been_ready  (been_ready)
   );

   task automatic check(input string tag, input logic [511:0] obs,
                        input logic [511:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit tb_status(input logic [7:0] b);
      return b == 8'hAA || b == 8'hFA || b == 8'hEE ||
             b == 8'hFE || b == 8'h00 || b == 8'hFF;
   endfunction

   // Pending prefixes are tracked as flags plus an idle-gap count
   task automatic model_step(input logic r, input logic v,
                             input logic [7:0] d);
      bit pending;
      if (r) begin
         m_ext = 0; m_brk = 0; m_skip = 0; m_gap = 0;
         m_kd = '0; m_lc = '0; m_br = 1'b0;
         return;
      end
      m_br = 1'b0;
      pending = m_ext || m_brk || (m_skip > 0);
      if (!v) begin
         if (pending) begin
            m_gap++;
            if (m_gap >= T) begin
               m_ext = 0; m_brk = 0; m_skip = 0; m_gap = 0;
            end
         end
         return;
      end
      m_gap = 0;
      if (m_skip > 0) begin
         m_skip--;
      end else if (d == 8'hE1 && !m_brk) begin
         m_skip = SKIP;
         m_ext  = 0;
      end else if (d == 8'hE0) begin
         m_ext = 1;
      end else if (d == 8'hF0) begin
         m_brk = 1;
      end else if (!m_ext && !m_brk && tb_status(d)) begin
      end else if (m_ext && (d == 8'h12 || d == 8'h59)) begin
         m_ext = 0; m_brk = 0;
      end else begin
         m_lc = {m_ext, d};
         m_kd[m_lc] = !m_brk;
         m_br = 1'b1;
         m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic tick(input logic r, input logic v, input logic [7:0] d);
      rst = r; byte_valid = v; byte_data = d;
      @(posedge clk);
      model_step(r, v, d);
      #1;
      if (been_ready === 1'b1) pulses++;
      check("ready", been_ready, m_br);
      check("last", last_change, m_lc);
      check("map", key_down, m_kd);
   endtask

   task automatic send(input logic [7:0] b);
      tick(1'b0, 1'b1, b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00);
   endtask

   logic [511:0] snap;
   logic [7:0]   tbl [15];

   initial begin
      tbl = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'hAA, 8'hFA,
              8'h00, 8'hFF, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1A, 8'h1C};
      tick(1'b1, 1'b0, 8'h00);
      tick(1'b1, 1'b1, 8'h1A);
      check("rst_map", key_down, '0);
      check("rst_last", last_change, 9'h000);
      check("rst_ready", been_ready, 1'b0);

      send(8'h1A);
      check("z_make_last", last_change, 9'h01A);
      check("z_make_bit", key_down[26], 1'b1);
      check("z_make_pulse", been_ready, 1'b1);
      send(8'hF0);
      check("brk_prefix_nopulse", been_ready, 1'b0);
      send(8'h1A);
      check("z_break_bit", key_down[26], 1'b0);
      check("z_break_pulse", been_ready, 1'b1);
      idle(1);
      check("pulse_one_cycle", been_ready, 1'b0);

      pulses = 0;
      send(8'hE0); send(8'h75);
      check("up_last", last_change, 9'h175);
      check("up_bit", key_down[373], 1'b1);
      send(8'hE0); send(8'hF0); send(8'h75);
      check("up_break_bit", key_down[373], 1'b0);
      check("up_pulses", pulses, 2);

      pulses = 0;
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      check("pause_nopulse", pulses, 0);
      send(8'h1C);
      check("pause_after_pulses", pulses, 1);
      check("pause_after_last", last_change, 9'h01C);

      send(8'hE0);
      idle(T);
      pulses = 0;
      send(8'h1A);
      check("timeout_last", last_change, 9'h01A);
      check("timeout_pulses", pulses, 1);

      snap = key_down;
      pulses = 0;
      send(8'hAA); send(8'hFA); send(8'hEE);
      check("status_nopulse", pulses, 0);
      check("status_map", key_down, snap);
      send(8'hE0); send(8'h12); send(8'hE0); send(8'h74);
      check("fake_pulses", pulses, 1);
      check("fake_last", last_change, 9'h174);

      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         send(8'hE0); send(8'h72);
      end
      check("repeat_pulses", pulses, 3);
      check("repeat_bit", key_down[370], 1'b1);

      send(8'hF0);
      tick(1'b1, 1'b0, 8'h00);
      check("mid_rst_map", key_down, '0);
      check("mid_rst_last", last_change, 9'h000);
      send(8'h72);
      check("post_rst_last", last_change, 9'h072);
      check("post_rst_bit", key_down[9'h072], 1'b1);

      for (int n = 0; n < 3000; n++) begin
         int k, g, gap;
         logic [7:0] b;
         k = $urandom_range(0, 15);
         if (k == 15) b = 8'($urandom);
         else b = tbl[k];
         if ($urandom_range(0, 199) == 0) tick(1'b1, 1'b0, 8'h00);
         send(b);
         g = $urandom_range(0, 9);
         if (g < 6) gap = 0;
         else if (g < 8) gap = $urandom_range(1, 3);
         else gap = $urandom_range(T - 2, T + 1);
         idle(gap);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
